neuron_layer_streamer: RTL and testbench
========================================

# neuron_layer_streamer

Reads a neuron layer's parallel value bus back out as a serial stream of (address, value) beats over a valid/ready handshake. It is the read-side counterpart of the layer's addressed load port. It sits between a `Neuron_Layer` instance and the next fully-connected stage, which consumes one neuron value per accepted beat. On `start` it snapshots the whole layer, so later writes into the layer do not corrupt a stream in progress.

## Interface
- `SIZE`, 16, width of one neuron value and of the address field.
- `LAYER_SZ`, 2, number of neurons in the layer; must satisfy 1 ≤ `LAYER_SZ` ≤ 2^`SIZE`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  begin a stream; sampled only in IDLE.
- `values`  in  [LAYER_SZ-1:0][SIZE-1:0]  layer contents; element i is neuron address i.
- `out_ready`  in  1  downstream can accept a beat.
- `out_valid`  out  1  beat present.
- `out_value`  out  SIZE  neuron value of the current beat.
- `out_address`  out  SIZE  neuron index of the current beat, zero-extended.
- `out_last`  out  1  current beat is the final beat of the stream.
- `busy`  out  1  high in SEND and DONE.
- `done`  out  1  one-cycle pulse after the stream completes.

## Operation
- States are IDLE, SEND and DONE.
- In IDLE with `start`=1:
  - latch `values` into the snapshot register;
  - set index to the first emitted address;
  - go to SEND.
- In SEND:
  - `out_valid`=1; `out_value`=snapshot[index]; `out_address`=index.
  - A beat transfers on any cycle with `out_valid` && `out_ready`.
  - On a transfer that is not the last, index advances to the next emitted address.
  - On a transfer with `out_last`=1, go to DONE.
- In DONE: `done`=1 for exactly one cycle, then go to IDLE.
- `start` is ignored outside IDLE. `values` is ignored except at the latch cycle.
- Without gating, addresses are emitted in order 0..LAYER_SZ-1. `out_last` is 1 when index = LAYER_SZ-1.
- The index counter is ceil(log2(LAYER_SZ)) bits wide, minimum 1. It never wraps past LAYER_SZ-1.

## Timing
- All outputs reset to 0, state resets to IDLE and the snapshot resets to 0.
- Reset asserted mid-stream aborts the stream immediately:
  - no `done` pulse is produced;
  - `out_valid` drops asynchronously.
- Latency from `start` to `out_valid`=1 is one cycle.
- Sustained throughput is one beat per cycle while `out_ready`=1.
- While `out_valid`=1 and `out_ready`=0:
  - `out_value`, `out_address` and `out_last` hold stable;
  - `out_valid` stays high.
- `out_valid` never drops without a transfer, except on reset.
- A full stream with `out_ready` held high takes:
  - 1 latch cycle;
  - LAYER_SZ SEND cycles;
  - 1 DONE cycle.
- `busy` is high from the cycle after `start` through the DONE cycle.
- `start` asserted in the DONE cycle is ignored. A new stream needs `start` asserted in IDLE.
- LAYER_SZ=1: a single beat with `out_address`=0 and `out_last`=1.

## Configuration
- Macro: `NEURON_STREAM_SKIP_ZERO_EN`.
- Defined:
  - neurons whose snapshot value is 0 are not emitted;
  - index jumps directly to the next nonzero address, via a combinational scan of the snapshot;
  - `out_last` marks the highest-addressed nonzero neuron;
  - if every snapshot value is 0, SEND is skipped: the `start` latch cycle goes to DONE and `done` pulses one cycle after `start` with no beats.
- Undefined: every neuron is emitted, including zeros; the zero-detect logic is not compiled.

## Test plan
- Full stream, LAYER_SZ=2, `values`[1]=h1111, `values`[0]=h8000, `out_ready`=1, pulse `start`:
  - beats (0,h8000,last=0) then (1,h1111,last=1);
  - `done` in the following cycle; `busy` low afterwards.
- Backpressure, same setup with `out_ready`=0 for 3 cycles after the first beat appears:
  - beat (0,h8000) held stable for all 3 cycles;
  - it transfers on the first cycle `out_ready`=1.
- Snapshot isolation: after `start`, change `values`[1] to h0008 during SEND; the stream still emits h1111 at address 1.
- Restart and ignore:
  - `start` held high through SEND and DONE produces only one stream;
  - reasserting `start` in IDLE produces a second identical stream.
- Reset mid-stream: assert `rst` while beat 0 is pending.
  - `out_valid`, `busy` and `done` go to 0 at once;
  - no `done` pulse;
  - the next `start` emits from address 0.
- With `NEURON_STREAM_SKIP_ZERO_EN`:
  - `values`={h0000,h8000} yields a single beat (0,h8000,last=1);
  - `values`={h0000,h0000} yields no beats and `done` one cycle after `start`.

Source files
------------

// File: rtl/neuron_layer_streamer.sv
// Streams a snapshot of a neuron layer's parallel value bus as (address, value) beats over valid/ready.
// Optional build macro NEURON_STREAM_SKIP_ZERO_EN suppresses beats for zero-valued neurons.
module neuron_layer_streamer #(
  parameter int SIZE     = 16,
  parameter int LAYER_SZ = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [LAYER_SZ-1:0][SIZE-1:0]  values,
  input  logic                           out_ready,
  output logic                           out_valid,
  output logic [SIZE-1:0]                out_value,
  output logic [SIZE-1:0]                out_address,
  output logic                           out_last,
  output logic                           busy,
  output logic                           done
);

  localparam int IW = (LAYER_SZ > 1) ? $clog2(LAYER_SZ) : 1;

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t                        state, state_nxt;
  logic [LAYER_SZ-1:0][SIZE-1:0] snap;
  logic [IW-1:0]                 idx, idx_nxt;
  logic                          load;
  logic [IW-1:0]                 first_idx, succ_idx;
  logic                          first_found, is_last;

`ifdef NEURON_STREAM_SKIP_ZERO_EN
  // First nonzero is scanned on the live bus because the snapshot is only written at that edge.
  always_comb begin
    first_idx   = '0;
    first_found = 1'b0;
    for (int unsigned i = 0; i < LAYER_SZ; i++) begin
      if (!first_found && values[i] != '0) begin
        first_idx   = IW'(i);
        first_found = 1'b1;
      end
    end
    succ_idx = idx;
    is_last  = 1'b1;
    for (int unsigned i = 0; i < LAYER_SZ; i++) begin
      if (is_last && i > 32'(idx) && snap[i] != '0) begin
        succ_idx = IW'(i);
        is_last  = 1'b0;
      end
    end
  end
`else
  always_comb begin
    first_idx   = '0;
    first_found = 1'b1;
    succ_idx    = idx + 1'b1;
    is_last     = (idx == IW'(LAYER_SZ - 1));
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      snap  <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (load) snap <= values;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          idx_nxt   = first_idx;
          state_nxt = first_found ? SEND : DONE;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (is_last) state_nxt = DONE;
          else         idx_nxt   = succ_idx;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_valid   = (state == SEND);
    out_value   = out_valid ? snap[idx] : '0;
    out_address = out_valid ? SIZE'(idx) : '0;
    out_last    = out_valid && is_last;
    busy        = (state != IDLE);
    done        = (state == DONE);
  end

endmodule

// File: tb/tb_neuron_layer_streamer.sv
// Self-checking bench for neuron_layer_streamer: directed scenarios plus randomized streams
// compared against a beat-list model built from the layer contents.
module tb_neuron_layer_streamer;
  localparam int W = 16;
  localparam int L = 2;
`ifdef NEURON_STREAM_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              out_ready = 1'b0;
  logic [L-1:0][W-1:0] values = '0;
  logic              out_valid, out_last, busy, done;
  logic [W-1:0]      out_value, out_address;

  int total = 0;
  int bad   = 0;

  neuron_layer_streamer #(.SIZE(W), .LAYER_SZ(L)) dut (
    .clk(clk), .rst(rst), .start(start), .values(values), .out_ready(out_ready),
    .out_valid(out_valid), .out_value(out_value), .out_address(out_address),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one stream and checks every cycle against the expected beat list.
  task automatic run_stream(input logic [L-1:0][W-1:0] v, input int pct, input int stalls,
                            input bit mutate, input bit hold_start);
    int         ea[$];
    logic [W-1:0] ev[$];
    int         k, cyc, n, st;
    for (int i = 0; i < L; i++)
      if (!SKIP || v[i] != '0) begin
        ea.push_back(i);
        ev.push_back(v[i]);
      end
    n  = ea.size();
    st = stalls;
    values = v;
    start  = 1'b1;
    out_ready = 1'b1;
    step();
    if (!hold_start) start = 1'b0;
    if (mutate) values = ~v;
    k = 0;
    cyc = 0;
    while (k < n && cyc < 100) begin
      chk("valid", out_valid, 1);
      chk("addr", out_address, ea[k]);
      chk("value", out_value, ev[k]);
      chk("last", out_last, (k == n - 1));
      chk("busy", busy, 1);
      chk("done_early", done, 0);
      if (st > 0) begin
        out_ready = 1'b0;
        st--;
      end else begin
        out_ready = ($urandom_range(99) < pct);
      end
      if (out_ready) k++;
      step();
      cyc++;
    end
    chk("beats", k, n);
    chk("done", done, 1);
    chk("valid_done", out_valid, 0);
    chk("busy_done", busy, 1);
    step();
    chk("done_once", done, 0);
    chk("busy_idle", busy, 0);
    chk("valid_idle", out_valid, 0);
    if (hold_start) begin
      start = 1'b0;
      step();
      chk("no_restart_valid", out_valid, 0);
      chk("no_restart_busy", busy, 0);
    end
  endtask

  initial begin
    logic [L-1:0][W-1:0] v;

    // reset state
    step();
    chk("rst_valid", out_valid, 0);
    chk("rst_value", out_value, 0);
    chk("rst_addr", out_address, 0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    step();

    // full stream, ready high
    v = {16'h1111, 16'h8000};
    run_stream(v, 100, 0, 1'b0, 1'b0);
    // backpressure: three stall cycles on the first beat
    run_stream(v, 100, 3, 1'b0, 1'b0);
    // snapshot isolation
    run_stream(v, 100, 0, 1'b1, 1'b0);
    // start held through SEND and DONE, then a second identical stream
    run_stream(v, 100, 0, 1'b0, 1'b1);
    run_stream(v, 100, 0, 1'b0, 1'b0);

    // reset while beat 0 is pending
    values = v;
    start = 1'b1;
    step();
    start = 1'b0;
    out_ready = 1'b0;
    chk("pend_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    step();
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      chk("post_rst_done", done, 0);
      chk("post_rst_valid", out_valid, 0);
    end
    run_stream(v, 100, 0, 1'b0, 1'b0);

    // zero-valued neurons
    v = {16'h0000, 16'h8000};
    run_stream(v, 100, 0, 1'b0, 1'b0);
    v = {16'h0000, 16'h0000};
    run_stream(v, 100, 0, 1'b0, 1'b0);
    v = {16'h00ff, 16'h0000};
    run_stream(v, 100, 1, 1'b0, 1'b0);

    // randomized streams with random backpressure
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < L; i++)
        v[i] = ($urandom_range(3) == 0) ? W'(0) : W'($urandom);
      run_stream(v, int'($urandom_range(100, 30)), int'($urandom_range(2)),
                 1'($urandom_range(1)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
